// File: rtl/gemm_dep_sched_if.sv
// Instruction handshake and gemm-core port bundle for gemm_dep_sched.
// master = upstream/gemm side, slave = scheduler side.
interface gemm_dep_sched_if #(
  parameter int unsigned INS_WIDTH = 128
) ();
  logic                 insn_valid;
  logic                 insn_ready;
  logic [INS_WIDTH-1:0] insn_data;
  logic [INS_WIDTH-1:0] gemm_insn;
  logic                 gemm_start;
  logic                 gemm_done;

  modport master (
    output insn_valid, insn_data, gemm_done,
    input  insn_ready, gemm_insn, gemm_start
  );

  modport slave (
    input  insn_valid, insn_data, gemm_done,
    output insn_ready, gemm_insn, gemm_start
  );
endinterface

// File: rtl/gemm_dep_sched.sv
// Dependency-token scheduler in front of the gemm core: holds each instruction
// until its pop tokens are available, issues it, then pushes tokens onward.
module gemm_dep_sched #(
  parameter int unsigned INS_WIDTH = 128,
  parameter int unsigned TOK_DEPTH = 8,
  parameter int unsigned CNT_WIDTH = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  gemm_dep_sched_if.slave      bus,
  input  logic                 prev_tok_in,
  input  logic                 next_tok_in,
  output logic                 prev_tok_out,
  output logic                 next_tok_out,
  output logic                 busy,
  output logic                 tok_err,
  output logic [31:0]          retired
);

  localparam int unsigned RET_WIDTH = 32;
  localparam logic [2:0]  OP_GEMM   = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DEP,
    S_ISSUE,
    S_WAIT_DONE,
    S_PUSH
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [INS_WIDTH-1:0] insn_q;
  logic [CNT_WIDTH-1:0] prev_cnt;
  logic [CNT_WIDTH-1:0] next_cnt;
  logic [CNT_WIDTH:0]   prev_step;
  logic [CNT_WIDTH:0]   next_step;
  logic                 capture;
  logic                 pop_prev_fire;
  logic                 pop_next_fire;
  logic                 dep_ok;
  logic [2:0]           opcode;
  logic                 pop_prev;
  logic                 pop_next;
  logic                 push_prev;
  logic                 push_next;

  assign opcode        = insn_q[2:0];
  assign pop_prev      = insn_q[3];
  assign pop_next      = insn_q[4];
  assign push_prev     = insn_q[5];
  assign push_next     = insn_q[6];
  assign bus.gemm_insn = insn_q;

  // Returns {overflow, next count}; increment and pop together cancel out.
  function automatic logic [CNT_WIDTH:0] cnt_step(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 inc,
    input logic                 dec
  );
    logic [CNT_WIDTH:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_WIDTH'(TOK_DEPTH)) r[CNT_WIDTH] = 1'b1;
      else                              r[CNT_WIDTH-1:0] = cnt + CNT_WIDTH'(1);
    end else if (dec && !inc) begin
      r[CNT_WIDTH-1:0] = cnt - CNT_WIDTH'(1);
    end
    return r;
  endfunction

  assign prev_step = cnt_step(prev_cnt, prev_tok_in, pop_prev_fire);
  assign next_step = cnt_step(next_cnt, next_tok_in, pop_next_fire);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state and state-decoded outputs; no input reaches an output here.
  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    pop_prev_fire  = 1'b0;
    pop_next_fire  = 1'b0;
    bus.insn_ready = 1'b0;
    bus.gemm_start = 1'b0;
    prev_tok_out   = 1'b0;
    next_tok_out   = 1'b0;
    busy           = 1'b1;
    dep_ok         = (!pop_prev || (prev_cnt != '0)) && (!pop_next || (next_cnt != '0));
    case (state)
      S_IDLE: begin
        bus.insn_ready = 1'b1;
        busy           = 1'b0;
        if (bus.insn_valid) begin
          capture   = 1'b1;
          state_nxt = S_WAIT_DEP;
        end
      end
      S_WAIT_DEP: begin
        if (dep_ok) begin
          pop_prev_fire = pop_prev;
          pop_next_fire = pop_next;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (opcode == OP_GEMM) begin
          bus.gemm_start = 1'b1;
          state_nxt      = S_WAIT_DONE;
        end else begin
          state_nxt = S_PUSH;
        end
      end
      S_WAIT_DONE: begin
        if (bus.gemm_done) state_nxt = S_PUSH;
      end
      S_PUSH: begin
        prev_tok_out = push_prev;
        next_tok_out = push_next;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Token counters, sticky overflow, held instruction and retire count.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prev_cnt <= '0;
      next_cnt <= '0;
      tok_err  <= 1'b0;
      insn_q   <= '0;
      retired  <= '0;
    end else begin
      prev_cnt <= prev_step[CNT_WIDTH-1:0];
      next_cnt <= next_step[CNT_WIDTH-1:0];
      if (prev_step[CNT_WIDTH] || next_step[CNT_WIDTH]) tok_err <= 1'b1;
      if (capture) insn_q <= bus.insn_data;
      if (state == S_PUSH) retired <= retired + RET_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gemm_dep_sched.sv
// Scoreboard bench for gemm_dep_sched: directed stimulus pushes expected events
// and per-cycle state checks; a negedge monitor pops and compares them.
module tb_gemm_dep_sched;

  localparam int K_START = 0;
  localparam int K_RET   = 1;
  localparam int K_STATE = 2;
  localparam int K_TMO   = 3;
  localparam int K_END   = 4;

  typedef struct {
    int           kind;
    int           cyc;
    logic [127:0] insn;
    logic         pt;
    logic         nt;
    logic [31:0]  ret;
    logic         rdy;
    logic         bsy;
    int           pc;
    int           nc;
    logic         err;
  } rec_t;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        prev_tok_in;
  logic        next_tok_in;
  logic        prev_tok_out;
  logic        next_tok_out;
  logic        busy;
  logic        tok_err;
  logic [31:0] retired;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  rec_t exp_q[$];
  rec_t chk_q[$];
  logic pt_q = 1'b0;
  logic nt_q = 1'b0;
  logic [31:0] last_ret = '0;

  gemm_dep_sched_if #(.INS_WIDTH(128)) bus ();

  gemm_dep_sched #(
    .INS_WIDTH(128),
    .TOK_DEPTH(8),
    .CNT_WIDTH(4)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .bus         (bus),
    .prev_tok_in (prev_tok_in),
    .next_tok_in (next_tok_in),
    .prev_tok_out(prev_tok_out),
    .next_tok_out(next_tok_out),
    .busy        (busy),
    .tok_err     (tok_err),
    .retired     (retired)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic got_ev(input rec_t g);
    rec_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event cycle=%0d got_kind=%0d want=none", cyc, g.kind);
    end else begin
      e = exp_q.pop_front();
      cmp("event_kind", g.kind, e.kind);
      cmp("event_cycle", g.cyc, e.cyc);
      if (e.kind == K_START) cmp("start_insn", g.insn, e.insn);
      if (e.kind == K_RET) begin
        cmp("prev_tok_out", g.pt, e.pt);
        cmp("next_tok_out", g.nt, e.nt);
        cmp("retired_event", g.ret, e.ret);
      end
    end
  endtask

  // Monitor: timed state checks, then output events.
  always @(negedge ap_clk) begin
    rec_t c;
    rec_t g;
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      c = chk_q.pop_front();
      if (c.kind == K_STATE) begin
        cmp("check_cycle", cyc, c.cyc);
        cmp("insn_ready", bus.insn_ready, c.rdy);
        cmp("busy", busy, c.bsy);
        cmp("prev_cnt", dut.prev_cnt, c.pc);
        cmp("next_cnt", dut.next_cnt, c.nc);
        cmp("tok_err", tok_err, c.err);
        cmp("retired", retired, c.ret);
        cmp("gemm_insn", bus.gemm_insn, c.insn);
      end else if (c.kind == K_END) begin
        cmp("pending_events", exp_q.size(), 0);
      end else begin
        total++;
        bad++;
        $display("FAIL handshake_timeout cycle=%0d got=no_ready want=ready", cyc);
      end
    end
    if (ap_rst_n) begin
      g = '{default: '0};
      g.cyc = cyc;
      if (bus.gemm_start) begin
        g.kind = K_START;
        g.insn = bus.gemm_insn;
        got_ev(g);
      end
      if (retired != last_ret) begin
        g.kind = K_RET;
        g.pt   = pt_q;
        g.nt   = nt_q;
        g.ret  = retired;
        got_ev(g);
      end
    end
    pt_q     = prev_tok_out;
    nt_q     = next_tok_out;
    last_ret = retired;
  end

  task automatic exp_state(input int c, input logic rdy, input logic bsy, input int pc,
                           input int nc, input logic err, input int ret, input logic [127:0] ins);
    rec_t r;
    r = '{default: '0};
    r.kind = K_STATE; r.cyc = c; r.rdy = rdy; r.bsy = bsy; r.pc = pc; r.nc = nc;
    r.err = err; r.ret = ret; r.insn = ins;
    chk_q.push_back(r);
  endtask

  task automatic exp_start(input int c, input logic [127:0] ins);
    rec_t r;
    r = '{default: '0};
    r.kind = K_START; r.cyc = c; r.insn = ins;
    exp_q.push_back(r);
  endtask

  task automatic exp_ret(input int c, input logic pt, input logic nt, input int ret);
    rec_t r;
    r = '{default: '0};
    r.kind = K_RET; r.cyc = c; r.pt = pt; r.nt = nt; r.ret = ret;
    exp_q.push_back(r);
  endtask

  task automatic push_mark(input int kind);
    rec_t r;
    r = '{default: '0};
    r.kind = kind; r.cyc = cyc + 1;
    chk_q.push_back(r);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  // Called just after a posedge; returns one cycle after the handshake.
  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    bus.insn_valid = 1'b1;
    bus.insn_data  = d;
    while (!bus.insn_ready && n < 40) begin
      tick(1);
      n++;
    end
    if (!bus.insn_ready) push_mark(K_TMO);
    tick(1);
    bus.insn_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] d1, d2, d3, d5, d6a, d6b;
    int h;
    d1  = {120'h11_2233_4455, 8'h03};
    d2  = {120'hBEEF_0000_CAFE, 8'h6A};
    d3  = {120'h3333_3333, 8'h10};
    d5  = {120'h5555_AAAA, 8'h02};
    d6a = {120'hA1A1_0001, 8'h02};
    d6b = {120'hB2B2_0002, 8'h42};

    ap_rst_n       = 1'b0;
    prev_tok_in    = 1'b0;
    next_tok_in    = 1'b0;
    bus.insn_valid = 1'b0;
    bus.insn_data  = '0;
    bus.gemm_done  = 1'b0;
    tick(3);
    ap_rst_n = 1'b1;
    exp_state(cyc, 1, 0, 0, 0, 0, 0, '0);
    tick(1);

    // No-op opcode 3, no dependencies
    h = cyc;
    exp_state(h + 1, 0, 1, 0, 0, 0, 0, d1);
    exp_state(h + 3, 0, 1, 0, 0, 0, 0, d1);
    exp_state(h + 4, 1, 0, 0, 0, 0, 1, d1);
    exp_ret(h + 4, 0, 0, 1);
    send(d1);
    tick(3);

    // GEMM blocked on prev token, released by a token at h+5
    h = cyc;
    exp_state(h + 4, 0, 1, 0, 0, 0, 1, d2);
    exp_state(h + 6, 0, 1, 1, 0, 0, 1, d2);
    exp_state(h + 7, 0, 1, 0, 0, 0, 1, d2);
    exp_state(h + 12, 1, 0, 0, 0, 0, 2, d2);
    exp_start(h + 7, d2);
    exp_ret(h + 12, 1, 1, 2);
    send(d2);
    tick(4);
    prev_tok_in = 1'b1;
    tick(1);
    prev_tok_in = 1'b0;
    tick(4);
    bus.gemm_done = 1'b1;
    tick(1);
    bus.gemm_done = 1'b0;
    tick(1);

    // Token in IDLE, then token coinciding with the WAIT_DEP pop
    h = cyc;
    exp_state(h + 1, 0, 1, 0, 1, 0, 2, d3);
    exp_state(h + 2, 0, 1, 0, 1, 0, 2, d3);
    exp_state(h + 4, 1, 0, 0, 1, 0, 3, d3);
    exp_ret(h + 4, 0, 0, 3);
    next_tok_in = 1'b1;
    send(d3);
    tick(1);
    next_tok_in = 1'b0;
    tick(2);

    // Nine prev tokens: saturate at 8 and set the sticky error
    h = cyc;
    exp_state(h + 8, 1, 0, 8, 1, 0, 3, d3);
    exp_state(h + 9, 1, 0, 8, 1, 1, 3, d3);
    prev_tok_in = 1'b1;
    tick(9);
    prev_tok_in = 1'b0;

    // Reset during WAIT_DONE; stale done afterwards must not retire
    h = cyc;
    exp_start(h + 2, d5);
    exp_state(h + 3, 0, 1, 8, 1, 1, 3, d5);
    exp_state(h + 4, 1, 0, 0, 0, 0, 0, '0);
    exp_state(h + 8, 1, 0, 0, 0, 0, 0, '0);
    send(d5);
    tick(3);
    ap_rst_n = 1'b0;
    tick(1);
    ap_rst_n = 1'b1;
    tick(1);
    bus.gemm_done = 1'b1;
    tick(1);
    bus.gemm_done = 1'b0;
    tick(1);

    // Back-to-back GEMMs, done three cycles after each start
    h = cyc;
    exp_start(h + 2, d6a);
    exp_ret(h + 7, 0, 0, 1);
    exp_state(h + 7, 1, 0, 0, 0, 0, 1, d6a);
    exp_state(h + 8, 0, 1, 0, 0, 0, 1, d6b);
    exp_start(h + 9, d6b);
    exp_ret(h + 14, 0, 1, 2);
    exp_state(h + 14, 1, 0, 0, 0, 0, 2, d6b);
    send(d6a);
    tick(4);
    bus.gemm_done = 1'b1;
    tick(1);
    bus.gemm_done = 1'b0;
    tick(1);
    send(d6b);
    tick(4);
    bus.gemm_done = 1'b1;
    tick(1);
    bus.gemm_done = 1'b0;
    tick(1);

    tick(3);
    push_mark(K_END);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_dep_sched.md
# gemm_dep_sched

Instruction scheduler sitting in front of the `gemm` core. It accepts 128-bit compute instructions over a valid/ready handshake and holds each one until its dependency tokens are available. It then issues the instruction to `gemm` with a one-cycle start pulse, waits for completion, and finally pushes dependency tokens to the neighbouring load and store stages. It owns the pop/push_prev/next_dep semantics carried in instruction bits [6:3].

## Interface
- `INS_WIDTH`, 128: instruction width; field layout is the standard compute-instruction layout.
- `TOK_DEPTH`, 8: maximum tokens each dependency counter can hold.
- `CNT_WIDTH`, 4: width of each token counter; must hold `TOK_DEPTH`.
- `ap_clk  in  1`: clock; the only clock.
- `ap_rst_n  in  1`: reset, asynchronous, active-low.
- `insn_valid  in  1`: upstream instruction valid.
- `insn_ready  out  1`: scheduler can accept an instruction.
- `insn_data  in  INS_WIDTH`: instruction word.
- `prev_tok_in  in  1`: one-cycle pulse; the load stage granted one token.
- `next_tok_in  in  1`: one-cycle pulse; the store stage granted one token.
- `prev_tok_out  out  1`: one-cycle pulse; token pushed to the load stage.
- `next_tok_out  out  1`: one-cycle pulse; token pushed to the store stage.
- `gemm_insn  out  INS_WIDTH`: instruction presented to `gemm`.
- `gemm_start  out  1`: one-cycle pulse starting `gemm`.
- `gemm_done  in  1`: one-cycle pulse; `gemm` finished.
- `busy  out  1`: high in any state other than IDLE.
- `tok_err  out  1`: sticky token-counter overflow flag.
- `retired  out  32`: count of completed instructions; wraps at 2^32.

## Operation
- **Counters:** `prev_cnt` and `next_cnt` are registered.
  - `*_tok_in` increments the counter; a pop decrements it.
  - An increment and a pop in the same cycle leave the counter unchanged.
  - An increment at `TOK_DEPTH` with no simultaneous pop saturates the counter and sets `tok_err`. `tok_err` clears only on reset.
- **Field use:**
  - opcode = [2:0]. Opcode 2 (GEMM) drives `gemm`; every other opcode is a no-op that still performs the token pops and pushes.
  - pop_prev = [3], pop_next = [4], push_prev = [5], push_next = [6].
- **IDLE:** `insn_ready` = 1. When `insn_valid` and `insn_ready` are both high, capture `insn_data` into `gemm_insn` and go to WAIT_DEP.
- **WAIT_DEP:** define ok = (!pop_prev || `prev_cnt` > 0) && (!pop_next || `next_cnt` > 0), evaluated on registered counts.
  - When ok holds, decrement the counters selected by pop_prev/pop_next in that same cycle and go to ISSUE.
  - Otherwise stay in WAIT_DEP.
- **ISSUE:** for opcode 2, drive `gemm_start` = 1 for this cycle and go to WAIT_DONE. For any other opcode, go to PUSH.
- **WAIT_DONE:** stay until `gemm_done` = 1, then go to PUSH. `gemm_done` is ignored in every other state.
- **PUSH:** pulse `prev_tok_out` = push_prev and `next_tok_out` = push_next for one cycle. Increment `retired`. Go to IDLE.
- **Hold rule:** `gemm_insn` stays stable from capture until the next capture; it is not cleared on return to IDLE.

## Timing
- **Reset values:** state IDLE, `insn_ready` = 1, `gemm_insn` = 0. `gemm_start`, `prev_tok_out`, `next_tok_out`, `busy` and `tok_err` = 0. `prev_cnt`, `next_cnt` and `retired` = 0.
- **Reset mid-operation:** asynchronous return to the reset values. In-flight pulses are cut and the held instruction is dropped.
- **Output style:** `insn_ready` and `busy` are combinational decodes of the state register. All other outputs are registered or are state decodes, with no combinational path from any input.
- **Latency with tokens already present:**
  - Handshake at cycle 0, WAIT_DEP at cycle 1, ISSUE at cycle 2.
  - For a non-GEMM opcode: PUSH at cycle 3, IDLE at cycle 4. The next handshake can happen at cycle 4, giving 4 cycles per no-op instruction.
  - For GEMM: if `gemm_done` arrives at cycle N (N ≥ 3), PUSH is at N+1 and IDLE at N+2.
- **Token timing:**
  - A token arriving in the cycle where WAIT_DEP evaluates becomes visible one cycle later.
  - A token arriving during the PUSH or IDLE cycles is counted normally.
  - Tokens arriving in any state are always counted.

## Test plan
- **No-op path:** reset, then send opcode 3 with no dependency bits. Required: no `gemm_start`; `retired` = 1; `insn_ready` falls for cycles 1-3 and rises at cycle 4.
- **Blocked GEMM:** send opcode 2 with pop_prev = 1 and `prev_cnt` = 0, then pulse `prev_tok_in` at cycle 5. Required: `gemm_start` at cycle 7; `prev_cnt` reads 0 afterwards; `gemm_done` at cycle 10 gives `prev_tok_out`/`next_tok_out` pulses at cycle 11 as per push bits [5]/[6].
- **Simultaneous increment and pop:** with `next_cnt` = 1 and pop_next = 1, pulse `next_tok_in` in the WAIT_DEP pass cycle. Required: `next_cnt` stays 1.
- **Overflow:** pulse `prev_tok_in` 9 times with `TOK_DEPTH` = 8. Required: `prev_cnt` = 8 and `tok_err` = 1 until reset.
- **Reset mid-operation:** assert `ap_rst_n` = 0 during WAIT_DONE. Required: immediately `busy` = 0, `insn_ready` = 1, counters 0; a stale `gemm_done` after release causes no push.
- **Back-to-back:** two GEMM instructions with no dependencies, `gemm_done` 3 cycles after each start. Required: exactly two `gemm_start` pulses; `gemm_insn` switches only at the second handshake; `retired` = 2.
